// File: rtl/transfer_datapath.sv
// transfer_datapath: register-transfer datapath executing one control-unit microcommand per clock
//
// Holds PC, SP, MA, MD, IR, A and AP; drives memory, IN and OUT ports; IR feeds the control FSM.
// Optional build macro: DP_STACK_GUARD_EN (SP saturates at its ends and raises sticky o_stack_err).
//
// Ports:
//   i_clk, i_rstn         clock (rising edge), asynchronous active-low reset
//   i_transfer_cmd        microcommand 0..F
//   i_inc_pc              increment PC (a PC load from MD/AP takes priority)
//   i_inc_dec_sp          01 = SP+1, 10 = SP-1, else hold
//   i_alu_res_to_ap       command A writes AP when 1, A when 0
//   i_reset_ir            clear IR (an IR load takes priority)
//   i_alu_r               ALU result
//   o_a, o_ap, o_md       ALU operand registers
//   o_ir                  instruction register / FSM opcode
//   o_pc, o_sp            program counter, stack pointer
//   o_mem_addr/o_mem_wdata/o_mem_we, i_mem_rdata   memory port (addr = MA, wdata = MD)
//   i_in_data             input port
//   o_out_data, o_out_strobe   output port register and its one-cycle strobe
//   o_stack_err           sticky stack-guard flag
module transfer_datapath #(
    parameter int                DATA_W  = 8,
    parameter int                ADDR_W  = 8,
    parameter logic [ADDR_W-1:0] PC_INIT = '0,
    parameter logic [ADDR_W-1:0] SP_INIT = ADDR_W'('hFF)
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [3:0]        i_transfer_cmd,
    input  logic              i_inc_pc,
    input  logic [1:0]        i_inc_dec_sp,
    input  logic              i_alu_res_to_ap,
    input  logic              i_reset_ir,
    input  logic [DATA_W-1:0] i_alu_r,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_ap,
    output logic [DATA_W-1:0] o_md,
    output logic [7:0]        o_ir,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_sp,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic [DATA_W-1:0] i_in_data,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_strobe,
    output logic              o_stack_err
);
    localparam logic [3:0] CMD_MA_PC  = 4'h1;
    localparam logic [3:0] CMD_MD_MEM = 4'h2;
    localparam logic [3:0] CMD_IR_MD  = 4'h3;
    localparam logic [3:0] CMD_MA_MD  = 4'h4;
    localparam logic [3:0] CMD_R_MD   = 4'h5;
    localparam logic [3:0] CMD_MA_AP  = 4'h6;
    localparam logic [3:0] CMD_MA_SP  = 4'h7;
    localparam logic [3:0] CMD_MD_R   = 4'h8;
    localparam logic [3:0] CMD_WRITE  = 4'h9;
    localparam logic [3:0] CMD_ALU    = 4'hA;
    localparam logic [3:0] CMD_PC_MD  = 4'hB;
    localparam logic [3:0] CMD_A_IN   = 4'hC;
    localparam logic [3:0] CMD_OUT    = 4'hD;
    localparam logic [3:0] CMD_PC_AP  = 4'hE;
    localparam logic [3:0] CMD_MD_PC  = 4'hF;

    // data <-> address moves keep the LSBs, zero-extending when widening
    function automatic logic [ADDR_W-1:0] d2a(input logic [DATA_W-1:0] d);
        return ADDR_W'(d);
    endfunction
    function automatic logic [DATA_W-1:0] a2d(input logic [ADDR_W-1:0] a);
        return DATA_W'(a);
    endfunction

    logic [ADDR_W-1:0] pc_q, pc_d, sp_q, sp_d, ma_q, ma_d;
    logic [DATA_W-1:0] md_q, md_d, a_q, a_d, ap_q, ap_d, out_q, out_d;
    logic [7:0]        ir_q, ir_d;
    logic              stb_q, stb_d, err_q, err_d;
    logic              sel_ap, sp_inc, sp_dec, sp_bad;
    logic [3:0]        cmd;

    assign cmd = i_transfer_cmd;

    always_comb begin
        sel_ap = ir_q[1] | (ir_q == 8'hC1);
        sp_inc = i_inc_dec_sp == 2'b01;
        sp_dec = i_inc_dec_sp == 2'b10;
`ifdef DP_STACK_GUARD_EN
        sp_bad = (sp_inc & (&sp_q)) | (sp_dec & ~(|sp_q));
`else
        sp_bad = 1'b0;
`endif
        pc_d  = cmd == CMD_PC_MD ? d2a(md_q) :
                cmd == CMD_PC_AP ? d2a(ap_q) :
                i_inc_pc         ? pc_q + ADDR_W'(1) : pc_q;
        sp_d  = sp_bad ? sp_q :
                sp_inc ? sp_q + ADDR_W'(1) :
                sp_dec ? sp_q - ADDR_W'(1) : sp_q;
        ma_d  = cmd == CMD_MA_PC ? pc_q :
                cmd == CMD_MA_MD ? d2a(md_q) :
                cmd == CMD_MA_AP ? d2a(ap_q) :
                cmd == CMD_MA_SP ? sp_q : ma_q;
        md_d  = cmd == CMD_MD_MEM ? i_mem_rdata :
                cmd == CMD_MD_R   ? (sel_ap ? ap_q : a_q) :
                cmd == CMD_MD_PC  ? a2d(pc_q) : md_q;
        ir_d  = cmd == CMD_IR_MD ? md_q[7:0] : i_reset_ir ? 8'h00 : ir_q;
        a_d   = (cmd == CMD_R_MD && !sel_ap)          ? md_q :
                (cmd == CMD_ALU && !i_alu_res_to_ap)  ? i_alu_r :
                cmd == CMD_A_IN                       ? i_in_data : a_q;
        ap_d  = (cmd == CMD_R_MD && sel_ap)           ? md_q :
                (cmd == CMD_ALU && i_alu_res_to_ap)   ? i_alu_r : ap_q;
        out_d = cmd == CMD_OUT ? a_q : out_q;
        stb_d = cmd == CMD_OUT;
        err_d = err_q | sp_bad;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            pc_q  <= PC_INIT;
            sp_q  <= SP_INIT;
            ma_q  <= '0;
            md_q  <= '0;
            ir_q  <= '0;
            a_q   <= '0;
            ap_q  <= '0;
            out_q <= '0;
            stb_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            ma_q  <= ma_d;
            md_q  <= md_d;
            ir_q  <= ir_d;
            a_q   <= a_d;
            ap_q  <= ap_d;
            out_q <= out_d;
            stb_q <= stb_d;
            err_q <= err_d;
        end
    end

    // gated by reset so an in-flight write is dropped the moment reset asserts
    assign o_mem_we     = i_rstn & (cmd == CMD_WRITE);
    assign o_mem_addr   = ma_q;
    assign o_mem_wdata  = md_q;
    assign o_pc         = pc_q;
    assign o_sp         = sp_q;
    assign o_md         = md_q;
    assign o_ir         = ir_q;
    assign o_a          = a_q;
    assign o_ap         = ap_q;
    assign o_out_data   = out_q;
    assign o_out_strobe = stb_q;
    assign o_stack_err  = err_q;
endmodule

// File: tb/tb_transfer_datapath.sv
// tb_transfer_datapath: directed bench with a behavioural model checked every cycle
module tb_transfer_datapath;
    logic       i_clk = 1'b0, i_rstn = 1'b0;
    logic [3:0] cmd = '0;
    logic       inc_pc = 1'b0, to_ap = 1'b0, rst_ir = 1'b0;
    logic [1:0] spc = '0;
    logic [7:0] alu_r = '0, in_data = '0;
    logic [7:0] o_a, o_ap, o_md, o_ir, o_pc, o_sp, o_mem_addr, o_mem_wdata, o_out_data, i_mem_rdata;
    logic       o_mem_we, o_out_strobe, o_stack_err;

    logic [7:0] mem [256];
    logic [7:0] mm  [256];
    logic [7:0] e_pc, e_sp, e_ma, e_md, e_ir, e_a, e_ap, e_out;
    logic       e_stb, e_err, chk_en = 1'b0;
    int checks = 0, failures = 0, we_cnt = 0, stb_cnt = 0, snap;

    transfer_datapath dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_transfer_cmd(cmd), .i_inc_pc(inc_pc),
        .i_inc_dec_sp(spc), .i_alu_res_to_ap(to_ap), .i_reset_ir(rst_ir), .i_alu_r(alu_r),
        .o_a(o_a), .o_ap(o_ap), .o_md(o_md), .o_ir(o_ir), .o_pc(o_pc), .o_sp(o_sp),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we),
        .i_mem_rdata(i_mem_rdata), .i_in_data(in_data), .o_out_data(o_out_data),
        .o_out_strobe(o_out_strobe), .o_stack_err(o_stack_err)
    );

    always #5 i_clk = ~i_clk;

    assign i_mem_rdata = mem[o_mem_addr];
    always @(posedge i_clk) if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        e_pc = 8'h00; e_sp = 8'hFF; e_ma = 0; e_md = 0; e_ir = 0;
        e_a = 0; e_ap = 0; e_out = 0; e_stb = 0; e_err = 0;
    endtask

    always @(negedge i_clk) begin
        if (chk_en) begin
            chk("pc", o_pc, e_pc);
            chk("sp", o_sp, e_sp);
            chk("ma", o_mem_addr, e_ma);
            chk("md", o_md, e_md);
            chk("wdata", o_mem_wdata, e_md);
            chk("ir", o_ir, e_ir);
            chk("a", o_a, e_a);
            chk("ap", o_ap, e_ap);
            chk("out", o_out_data, e_out);
            chk("strobe", o_out_strobe, e_stb);
            chk("stack_err", o_stack_err, e_err);
            chk("we", o_mem_we, i_rstn && cmd == 4'h9);
        end
        if (o_mem_we) we_cnt++;
        if (o_out_strobe) stb_cnt++;
    end

    // one clock: apply a microcommand, predict the resulting register file, advance
    task automatic step(input logic [3:0] c, input logic ipc = 0, input logic [1:0] sc = 0,
                        input logic tap = 0, input logic rir = 0, input logic [7:0] r = 0,
                        input logic [7:0] din = 0);
        logic [7:0] n_pc, n_ma, n_md, n_ir, n_a, n_ap, n_out, n_sp;
        logic       selap, n_err;
        int         s;
        cmd = c; inc_pc = ipc; spc = sc; to_ap = tap; rst_ir = rir; alu_r = r; in_data = din;
        selap = e_ir[1] || e_ir == 8'hC1;
        n_pc = (ipc && c != 4'hB && c != 4'hE) ? e_pc + 8'd1 : e_pc;
        n_ma = e_ma; n_md = e_md; n_a = e_a; n_ap = e_ap; n_out = e_out;
        n_ir = c == 4'h3 ? e_md : rir ? 8'h00 : e_ir;
        case (c)
            4'h1: n_ma = e_pc;
            4'h2: n_md = mm[e_ma];
            4'h4: n_ma = e_md;
            4'h5: if (selap) n_ap = e_md; else n_a = e_md;
            4'h6: n_ma = e_ap;
            4'h7: n_ma = e_sp;
            4'h8: n_md = selap ? e_ap : e_a;
            4'hA: if (tap) n_ap = r; else n_a = r;
            4'hB: n_pc = e_md;
            4'hC: n_a = din;
            4'hD: n_out = e_a;
            4'hE: n_pc = e_ap;
            4'hF: n_md = e_pc;
            default: ;
        endcase
        s = int'(e_sp) + int'(sc == 2'b01) - int'(sc == 2'b10);
        n_err = e_err;
        n_sp = 8'(s);
`ifdef DP_STACK_GUARD_EN
        if (s < 0 || s > 255) begin
            n_sp = e_sp;
            n_err = 1'b1;
        end
`endif
        @(posedge i_clk);
        if (c == 4'h9) mm[e_ma] = e_md;
        e_pc = n_pc; e_sp = n_sp; e_ma = n_ma; e_md = n_md; e_ir = n_ir;
        e_a = n_a; e_ap = n_ap; e_out = n_out; e_stb = c == 4'hD; e_err = n_err;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin mem[i] = 0; mm[i] = 0; end
        mem[0] = 8'h19; mm[0] = 8'h19;
        mem[1] = 8'h23; mm[1] = 8'h23;
        mem[2] = 8'h40; mm[2] = 8'h40;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1 i_rstn = 1'b1;
        chk_en = 1'b1;
        chk("rst_pc", o_pc, 8'h00);
        chk("rst_sp", o_sp, 8'hFF);
        chk("rst_a", o_a, 8'h00);
        chk("rst_ir", o_ir, 8'h00);
        chk("rst_we", o_mem_we, 1'b0);
        chk("rst_strobe", o_out_strobe, 1'b0);
        // fetch
        step(4'h1); step(4'h2, 1); step(4'h3);
        chk("fetch_ma", o_mem_addr, 8'h00);
        chk("fetch_md", o_md, 8'h19);
        chk("fetch_pc", o_pc, 8'h01);
        chk("fetch_ir", o_ir, 8'h19);
        // store: IR=23, MA=40, AP=5A
        step(4'h1, 1); step(4'h2); step(4'h3);
        step(4'h1); step(4'h2); step(4'h4);
        step(4'hA, 0, 0, 1, 0, 8'h5A);
        snap = we_cnt;
        step(4'h8);
        chk("store_md", o_md, 8'h5A);
        step(4'h9); step(4'h0);
        chk("store_mem", mem[8'h40], 8'h5A);
        chk("store_we_cycles", we_cnt - snap, 1);
        // push: IR=2C, A=3C
        step(4'hA, 0, 0, 1, 0, 8'h2C); step(4'h8); step(4'h3);
        step(4'hC, 0, 0, 0, 0, 0, 8'h3C);
        step(4'h0, 0, 2'b10); step(4'h7); step(4'h8); step(4'h9); step(4'h0);
        chk("push_sp", o_sp, 8'hFE);
        chk("push_ma", o_mem_addr, 8'hFE);
        chk("push_mem", mem[8'hFE], 8'h3C);
        // call: IR=C1 (equality select), PC=12, MD=80
        step(4'hC, 0, 0, 0, 0, 0, 8'hC1); step(4'h8); step(4'h3);
        step(4'hA, 0, 0, 1, 0, 8'h12); step(4'hE);
        step(4'hA, 0, 0, 1, 0, 8'h80); step(4'h8);
        step(4'hA, 0, 0, 1, 0, 8'h00);
        step(4'h5); step(4'h7); step(4'hF); step(4'h9); step(4'hE); step(4'h0);
        chk("call_ap", o_ap, 8'h80);
        chk("call_mem", mem[8'hFE], 8'h12);
        chk("call_pc", o_pc, 8'h80);
        // SP boundary
        step(4'h7, 0, 2'b10);
        chk("sp_old_to_ma", o_mem_addr, 8'hFE);
        repeat (253) step(4'h0, 0, 2'b10);
        chk("sp_zero", o_sp, 8'h00);
        chk("err_clear", o_stack_err, 1'b0);
        step(4'h0, 0, 2'b10);
`ifdef DP_STACK_GUARD_EN
        chk("guard_sp", o_sp, 8'h00);
        chk("guard_err", o_stack_err, 1'b1);
        step(4'h0, 0, 2'b01); step(4'h0);
        chk("guard_sticky", o_stack_err, 1'b1);
`else
        chk("wrap_sp", o_sp, 8'hFF);
        chk("wrap_err", o_stack_err, 1'b0);
        step(4'h0, 0, 2'b01);
        chk("wrap_up_sp", o_sp, 8'h00);
`endif
        // PC wrap and load priority
        step(4'hA, 0, 0, 1, 0, 8'hFF); step(4'hE);
        step(4'h0, 1);
        chk("pc_wrap", o_pc, 8'h00);
        step(4'hE, 1);
        chk("pc_load_wins", o_pc, 8'hFF);
        step(4'hF, 1);
        chk("mdpc_old", o_md, 8'hFF);
        chk("mdpc_pc", o_pc, 8'h00);
        // IR load vs clear
        step(4'h3, 0, 0, 0, 1);
        chk("ir_load_wins", o_ir, 8'hFF);
        step(4'h0, 0, 0, 0, 1);
        chk("ir_clear", o_ir, 8'h00);
        // I/O
        snap = stb_cnt;
        step(4'hC, 0, 0, 0, 0, 0, 8'hA7); step(4'hD); step(4'h0); step(4'h0);
        chk("io_a", o_a, 8'hA7);
        chk("io_out", o_out_data, 8'hA7);
        chk("io_strobe_cycles", stb_cnt - snap, 1);
        // asynchronous reset in the middle of a write cycle
        cmd = 4'h9;
        #2 i_rstn = 1'b0;
        model_reset();
        #1;
        chk("async_we", o_mem_we, 1'b0);
        chk("async_pc", o_pc, 8'h00);
        chk("async_sp", o_sp, 8'hFF);
        chk("async_out", o_out_data, 8'h00);
        @(posedge i_clk);
        #1 cmd = 4'h0; i_rstn = 1'b1;
        step(4'h1); step(4'h2);
        chk("post_reset_md", o_md, mm[0]);
        chk("post_reset_mem", mem[8'hFE], 8'h12);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
